// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the DMT-VLC transmit frame scheduler.
package tx_sched_pkg;

  localparam int SAMPLE_W      = 28;
  localparam int SHORT_LEN_DEF = 161;
  localparam int LONG_LEN_DEF  = 289;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX =
    {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN =
    {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHORT = 3'd1,
    ST_LONG  = 3'd2,
    ST_DATA  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // Clamp a 3-term sum (two guard bits) into the sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(
    input logic signed [SAMPLE_W+1:0] s
  );
    logic signed [SAMPLE_W+1:0] hi;
    logic signed [SAMPLE_W+1:0] lo;
    hi = {{2{SAMPLE_MAX[SAMPLE_W-1]}}, SAMPLE_MAX};
    lo = {{2{SAMPLE_MIN[SAMPLE_W-1]}}, SAMPLE_MIN};
    if (s > hi) begin
      return SAMPLE_MAX;
    end else if (s < lo) begin
      return SAMPLE_MIN;
    end else begin
      return s[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tx_sample_merge.sv
// Registered 3-input signed saturating adder; invalid inputs contribute 0.
module tx_sample_merge
  import tx_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] a_seq,
  input  logic                       a_valid,
  input  logic signed [SAMPLE_W-1:0] b_seq,
  input  logic                       b_valid,
  input  logic signed [SAMPLE_W-1:0] c_seq,
  input  logic                       c_valid,
  output logic signed [SAMPLE_W-1:0] out_seq,
  output logic                       out_valid
);

  logic signed [SAMPLE_W+1:0] sum;
  logic signed [SAMPLE_W-1:0] out_seq_d;
  logic signed [SAMPLE_W-1:0] out_seq_q;
  logic                       out_valid_d;
  logic                       out_valid_q;

  always_comb begin
    sum = '0;
    if (a_valid) sum = sum + {{2{a_seq[SAMPLE_W-1]}}, a_seq};
    if (b_valid) sum = sum + {{2{b_seq[SAMPLE_W-1]}}, b_seq};
    if (c_valid) sum = sum + {{2{c_seq[SAMPLE_W-1]}}, c_seq};
    out_seq_d   = sat_sample(sum);
    out_valid_d = a_valid | b_valid | c_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_seq_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_seq_q   <= out_seq_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_seq   = out_seq_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/tx_frame_scheduler.sv
// DMT-VLC transmit frame sequencer: STF, LTF, payload, then a 2-cycle flush.
// Define TX_FIELD_OVERLAP_EN to overlap consecutive field ACK windows by one cycle.
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int SHORT_LEN = SHORT_LEN_DEF,
  parameter int LONG_LEN  = LONG_LEN_DEF,
  parameter int CNT_W     = 9
) (
  input  logic                       SYS_CLK,
  input  logic                       PHY_RST,
  input  logic                       TX_START,
  input  logic                       TX_ABORT,
  input  logic signed [SAMPLE_W-1:0] SHORT_SEQ,
  input  logic                       SHORT_VALID,
  input  logic signed [SAMPLE_W-1:0] LONG_SEQ,
  input  logic                       LONG_VALID,
  input  logic signed [SAMPLE_W-1:0] DATA_SEQ,
  input  logic                       DATA_VALID,
  input  logic                       DATA_LAST,
  output logic                       SHORT_ACK,
  output logic                       LONG_ACK,
  output logic                       DATA_ACK,
  output logic signed [SAMPLE_W-1:0] TX_SAMPLE,
  output logic                       TX_SAMPLE_VALID,
  output logic                       TX_BUSY,
  output logic                       TX_DONE
);

  localparam logic [CNT_W-1:0] SHORT_END = CNT_W'(SHORT_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             short_ack_d, short_ack_q;
  logic             long_ack_d, long_ack_q;
  logic             data_ack_d, data_ack_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             long_pre;
  logic             data_pre;

`ifdef TX_FIELD_OVERLAP_EN
  // LONG already saw one ACK cycle inside SHORT, so it runs one cycle shorter.
  localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(LONG_LEN - 2);
  localparam logic [CNT_W-1:0] SHORT_PRE = CNT_W'(SHORT_LEN - 2);
  localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_LEN - 3);
  assign long_pre = (state_q == ST_SHORT) && (cnt_q == SHORT_PRE);
  assign data_pre = (state_q == ST_LONG) && (cnt_q == LONG_PRE);
`else
  localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(LONG_LEN - 1);
  assign long_pre = 1'b0;
  assign data_pre = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (TX_START) state_d = ST_SHORT;
      end
      ST_SHORT: begin
        if (cnt_q == SHORT_END) begin
          state_d = ST_LONG;
          cnt_d   = '0;
        end
      end
      ST_LONG: begin
        if (cnt_q == LONG_END) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        cnt_d = '0;
        if (DATA_VALID && DATA_LAST) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        done_d = (cnt_q == '0);
        if (cnt_q == FLUSH_END) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort also drops a coincident start while idle.
    if (TX_ABORT) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
    short_ack_d = (state_d == ST_SHORT);
    long_ack_d  = (state_d == ST_LONG) || (long_pre && !TX_ABORT);
    data_ack_d  = (state_d == ST_DATA) || (data_pre && !TX_ABORT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge SYS_CLK) begin
    if (PHY_RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      short_ack_q <= 1'b0;
      long_ack_q  <= 1'b0;
      data_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      short_ack_q <= short_ack_d;
      long_ack_q  <= long_ack_d;
      data_ack_q  <= data_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  tx_sample_merge u_merge (
    .clk       (SYS_CLK),
    .rst       (PHY_RST),
    .a_seq     (SHORT_SEQ),
    .a_valid   (SHORT_VALID),
    .b_seq     (LONG_SEQ),
    .b_valid   (LONG_VALID),
    .c_seq     (DATA_SEQ),
    .c_valid   (DATA_VALID),
    .out_seq   (TX_SAMPLE),
    .out_valid (TX_SAMPLE_VALID)
  );

  assign SHORT_ACK = short_ack_q;
  assign LONG_ACK  = long_ack_q;
  assign DATA_ACK  = data_ack_q;
  assign TX_BUSY   = busy_q;
  assign TX_DONE   = done_q;

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Sequences one DMT-VLC transmit frame in order: short training field, long training field, then payload. Drives the enable (`*_ACK`) inputs of the short-training generator, the long-training generator and the payload/IFFT path, and merges their sample streams into one registered 28-bit sample stream for the DAC front end. Sits between the MAC-side frame request and the existing sequence generators.

## Interface

**Parameters**
- `SHORT_LEN`, default 161: number of cycles `SHORT_ACK` is held high (160 samples plus 1 tail sample).
- `LONG_LEN`, default 289: number of cycles `LONG_ACK` is held high (32 CP + 2×128 + 1 tail sample).
- `CNT_W`, default 9: width of the field counter; must satisfy `2^CNT_W > max(SHORT_LEN, LONG_LEN)`.

**Ports**
- `SYS_CLK`, in, 1: the single clock.
- `PHY_RST`, in, 1: reset, synchronous, active-high.
- `TX_START`, in, 1: frame request pulse; sampled only in IDLE.
- `TX_ABORT`, in, 1: abandons the frame in progress.
- `SHORT_SEQ`, in, 28: signed sample from the short generator.
- `SHORT_VALID`, in, 1: valid for `SHORT_SEQ`.
- `LONG_SEQ`, in, 28: signed sample from `LongTrainingSeqGen`.
- `LONG_VALID`, in, 1: valid for `LONG_SEQ`.
- `DATA_SEQ`, in, 28: signed payload sample.
- `DATA_VALID`, in, 1: valid for `DATA_SEQ`.
- `DATA_LAST`, in, 1: qualifies the final payload sample; meaningful only with `DATA_VALID`.
- `SHORT_ACK`, out, 1: enable to the short generator.
- `LONG_ACK`, out, 1: enable to the long generator.
- `DATA_ACK`, out, 1: enable to the payload path.
- `TX_SAMPLE`, out, 28: merged signed output sample.
- `TX_SAMPLE_VALID`, out, 1: valid for `TX_SAMPLE`.
- `TX_BUSY`, out, 1: high from the cycle after an accepted `TX_START` until `TX_DONE`.
- `TX_DONE`, out, 1: one-cycle pulse when the frame completes.

## Operation

**States:** IDLE, SHORT, LONG, DATA, FLUSH.

**Transitions**
- IDLE → SHORT when `TX_START` is high.
- SHORT → LONG after the counter reaches `SHORT_LEN-1`.
- LONG → DATA after the counter reaches `LONG_LEN-1`.
- DATA → FLUSH on `DATA_VALID && DATA_LAST`.
- FLUSH → IDLE after 2 cycles. `TX_DONE` pulses on the exit cycle.

**ACK outputs**
- Each ACK is a registered decode of the state.
- The counter clears on every state entry and increments each cycle in SHORT and LONG.
- `DATA_ACK` stays high throughout DATA. It drops in the cycle after `DATA_LAST` is sampled.

**Merge path**
- Registered: `TX_SAMPLE_VALID <= SHORT_VALID | LONG_VALID | DATA_VALID`.
- `TX_SAMPLE` is the sum of all valid inputs (invalid inputs contribute 0), saturated to the signed 28-bit range [-2^27, 2^27-1].
- When no input is valid, `TX_SAMPLE` is 0.

**Boundary conditions**
- `TX_START` outside IDLE is ignored.
- `TX_ABORT` in any non-IDLE state:
  - next cycle: all ACKs low, state IDLE, `TX_BUSY` low;
  - no `TX_DONE` pulse;
  - the merge path still forwards any in-flight valid sample.
- `TX_ABORT` and `TX_START` together in IDLE: abort wins and the start is dropped.
- A `PHY_RST` mid-frame behaves like abort and also clears the merge registers.
- `DATA_VALID` bubbles during DATA are forwarded as `TX_SAMPLE_VALID` bubbles. There is no timeout.

**Reset values:** all outputs 0, state IDLE, counter 0.

## Timing

- `TX_START` sampled high at cycle t → `SHORT_ACK` high over [t+1, t+SHORT_LEN].
- Without overlap (see Configuration):
  - `LONG_ACK` is high over [t+SHORT_LEN+1, t+SHORT_LEN+LONG_LEN];
  - `DATA_ACK` rises at t+SHORT_LEN+LONG_LEN+1.
- Generators register one cycle after their ACK; the merge adds one more. The first `TX_SAMPLE_VALID` is therefore at t+3.
- Sample latency from any `*_VALID` to `TX_SAMPLE_VALID` is 1 cycle.
- `DATA_LAST` sampled at cycle d → `TX_DONE` at d+2, aligned with the cycle after the last `TX_SAMPLE_VALID`. `TX_BUSY` falls at d+3.

## Configuration

`TX_FIELD_OVERLAP_EN`
- **Defined:**
  - each following field's ACK rises one cycle early, so consecutive ACK windows overlap by exactly one cycle (SHORT/LONG, LONG/DATA);
  - the halved tail sample of one field and the halved head sample of the next arrive together and are summed by the merge path (windowed boundary);
  - frame length shrinks by 1 sample per boundary;
  - total preamble output is SHORT_LEN+LONG_LEN-1 samples.
- **Undefined:**
  - ACK windows are strictly back to back;
  - at most one input is valid per cycle, so the adder reduces to a mux plus saturation (sum logic still present).

## Structure

- **Package `tx_sched_pkg`:**
  - state enum;
  - 28-bit sample width constant;
  - saturation limits `SAMPLE_MAX` / `SAMPLE_MIN`;
  - default field lengths.
- **Sub-module `tx_sample_merge`:** 3-input signed saturating adder with valid OR and an output register.
- The top level holds the FSM, the counter and the ACK registers.

## Test plan

- Reset, then `TX_START` pulse with a payload of 10 samples, `DATA_LAST` on the 10th (overlap undefined):
  - `SHORT_ACK` high for 161 cycles, `LONG_ACK` for 289 cycles;
  - `TX_SAMPLE_VALID` count = 460;
  - `TX_DONE` exactly once.
- Same stimulus with `TX_FIELD_OVERLAP_EN` defined:
  - exactly one cycle with `SHORT_ACK` and `LONG_ACK` both high;
  - output count = 458;
  - boundary sample = sum of both halved inputs.
- Saturation: forced overlap with inputs 0x7FFFFFF + 0x0000010 → `TX_SAMPLE` = 0x7FFFFFF; inputs 0x8000000 + 0xFFFFFFF → 0x8000000.
- `TX_ABORT` at counter 100 of LONG:
  - next cycle all ACKs 0 and `TX_BUSY` 0;
  - no `TX_DONE`;
  - a new `TX_START` 2 cycles later restarts SHORT at count 0.
- `TX_START` re-pulsed during DATA and again together with `TX_ABORT` in IDLE → both ignored, state sequence unchanged.
- Payload with `DATA_VALID` low every other cycle for 8 samples → 8 output valids with matching bubbles; `TX_DONE` 2 cycles after `DATA_LAST`.
